// File: rtl/decode_ctrl_stage_pkg.sv
// Shared ID-stage control types: opcodes, addressing modes,
// condition codes, the control bundle and mnemonic helpers.
package ctrl_pkg;

  localparam int KW_LEN = 48;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_RSB = 4'b0011,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSC = 4'b0111,
    OP_TST = 4'b1000,
    OP_TEQ = 4'b1001,
    OP_CMP = 4'b1010,
    OP_CMN = 4'b1011,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_BIC = 4'b1110,
    OP_MVN = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    AM_IMM32 = 2'b00,
    AM_SHIFT = 2'b01,
    AM_IMM12 = 2'b10,
    AM_REG   = 2'b11
  } am_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    opcode_e opcode;
    am_e     am;
    logic    s_enable;
    logic    load_instr;
    logic    rf_enable;
    logic    size_enable;
    logic    rw_enable;
    logic    enable_signal;
    logic    bl_instr;
    logic    b_instr;
  } ctrl_bundle_t;

  // EX copy carries everything but B, which is consumed in ID
  typedef struct packed {
    opcode_e opcode;
    am_e     am;
    logic    s_enable;
    logic    load_instr;
    logic    rf_enable;
    logic    size_enable;
    logic    rw_enable;
    logic    enable_signal;
    logic    bl_instr;
  } ex_bundle_t;

  localparam logic [KW_LEN-1:0] KW_NOP  = "NOP   ";
  localparam logic [KW_LEN-1:0] KW_B    = "B     ";
  localparam logic [KW_LEN-1:0] KW_BL   = "BL    ";
  localparam logic [KW_LEN-1:0] KW_LDR  = "LDR   ";
  localparam logic [KW_LEN-1:0] KW_LDRB = "LDRB  ";
  localparam logic [KW_LEN-1:0] KW_STR  = "STR   ";
  localparam logic [KW_LEN-1:0] KW_STRB = "STRB  ";

  function automatic logic [KW_LEN-1:0] op_kw(input opcode_e op);
    logic [KW_LEN-1:0] k;
    unique case (op)
      OP_AND: k = "AND   ";
      OP_EOR: k = "EOR   ";
      OP_SUB: k = "SUB   ";
      OP_RSB: k = "RSB   ";
      OP_ADD: k = "ADD   ";
      OP_ADC: k = "ADC   ";
      OP_SBC: k = "SBC   ";
      OP_RSC: k = "RSC   ";
      OP_TST: k = "TST   ";
      OP_TEQ: k = "TEQ   ";
      OP_CMP: k = "CMP   ";
      OP_CMN: k = "CMN   ";
      OP_ORR: k = "ORR   ";
      OP_MOV: k = "MOV   ";
      OP_BIC: k = "BIC   ";
      OP_MVN: k = "MVN   ";
      default: k = KW_NOP;
    endcase
    return k;
  endfunction

  function automatic logic [KW_LEN-1:0] ls_kw(
    input logic load,
    input logic byte_q
  );
    logic [KW_LEN-1:0] k;
    unique case ({load, byte_q})
      2'b10:   k = KW_LDR;
      2'b11:   k = KW_LDRB;
      2'b00:   k = KW_STR;
      default: k = KW_STRB;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_cond_eval.sv
// Condition-field evaluator: true when cond holds for {N,Z,C,V}.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c & !z;
      COND_LS: cond_true = !c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// ID-stage control: decode, stall mux, branch resolve and
// the registered EX-stage control copy.
module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int KW_W = 48
) (
  input  logic            clk,
  input  logic            R,
  input  logic [31:0]     instruction,
  input  logic            stall,
  input  logic [3:0]      flags,
  output logic [3:0]      ID_opcode,
  output logic [1:0]      ID_AM,
  output logic            ID_S_enable,
  output logic            ID_load_instr,
  output logic            ID_RF_enable,
  output logic            ID_Size_enable,
  output logic            ID_RW_enable,
  output logic            ID_Enable_signal,
  output logic            ID_BL_instr,
  output logic            ID_B_instr,
  output logic [KW_W-1:0] keyword,
  output logic            Branch,
  output logic            BranchL,
  output logic [3:0]      EX_opcode,
  output logic [1:0]      EX_AM,
  output logic            EX_S_enable,
  output logic            EX_load_instr,
  output logic            EX_RF_enable,
  output logic            EX_Size_enable,
  output logic            EX_RW_enable,
  output logic            EX_Enable_signal,
  output logic            EX_BL_instr
);

  ctrl_bundle_t      dec;
  ctrl_bundle_t      id;
  ex_bundle_t        ex_d, ex_q;
  logic [KW_LEN-1:0] kw;
  logic              cond_true;
  logic              unused_bits;

  assign unused_bits = ^instruction[19:0];

  always_comb begin
    dec = '0;
    kw  = KW_NOP;
    // all-zero word is the canonical NOP, not AND EQ
    if (|instruction) begin
      unique case (instruction[27:25])
        3'b000, 3'b001: begin
          dec.opcode    = opcode_e'(instruction[24:21]);
          dec.am        = instruction[25] ? AM_IMM32 : AM_SHIFT;
          dec.s_enable  = instruction[20];
          dec.rf_enable = (instruction[24:23] != 2'b10);
          kw = op_kw(opcode_e'(instruction[24:21]));
        end
        3'b010, 3'b011: begin
          dec.opcode        = instruction[23] ? OP_ADD : OP_SUB;
          dec.am            = instruction[25] ? AM_REG : AM_IMM12;
          dec.enable_signal = 1'b1;
          dec.load_instr    = instruction[20];
          dec.rf_enable     = instruction[20];
          dec.rw_enable     = !instruction[20];
          dec.size_enable   = !instruction[22];
          kw = ls_kw(instruction[20], instruction[22]);
        end
        3'b101: begin
          dec.opcode   = OP_ADD;
          dec.am       = AM_IMM32;
          dec.b_instr  = !instruction[24];
          dec.bl_instr = instruction[24];
          kw = instruction[24] ? KW_BL : KW_B;
        end
        default: ;
      endcase
    end
  end

  assign id = stall ? '0 : dec;

  cond_eval u_cond_eval (
    .cond      (instruction[31:28]),
    .flags     (flags),
    .cond_true (cond_true)
  );

  assign Branch  = cond_true & (id.b_instr | id.bl_instr);
  assign BranchL = cond_true & id.bl_instr;

  always_comb begin
    ex_d               = '0;
    ex_d.opcode        = id.opcode;
    ex_d.am            = id.am;
    ex_d.s_enable      = id.s_enable;
    ex_d.load_instr    = id.load_instr;
    ex_d.rf_enable     = id.rf_enable;
    ex_d.size_enable   = id.size_enable;
    ex_d.rw_enable     = id.rw_enable;
    ex_d.enable_signal = id.enable_signal;
    ex_d.bl_instr      = id.bl_instr;
  end

  always_ff @(posedge clk) begin
    if (!R) ex_q <= '0;
    else    ex_q <= ex_d;
  end

  assign keyword          = KW_W'(kw);
  assign ID_opcode        = id.opcode;
  assign ID_AM            = id.am;
  assign ID_S_enable      = id.s_enable;
  assign ID_load_instr    = id.load_instr;
  assign ID_RF_enable     = id.rf_enable;
  assign ID_Size_enable   = id.size_enable;
  assign ID_RW_enable     = id.rw_enable;
  assign ID_Enable_signal = id.enable_signal;
  assign ID_BL_instr      = id.bl_instr;
  assign ID_B_instr       = id.b_instr;

  assign EX_opcode        = ex_q.opcode;
  assign EX_AM            = ex_q.am;
  assign EX_S_enable      = ex_q.s_enable;
  assign EX_load_instr    = ex_q.load_instr;
  assign EX_RF_enable     = ex_q.rf_enable;
  assign EX_Size_enable   = ex_q.size_enable;
  assign EX_RW_enable     = ex_q.rw_enable;
  assign EX_Enable_signal = ex_q.enable_signal;
  assign EX_BL_instr      = ex_q.bl_instr;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage with an EX scoreboard.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        R;
  logic [31:0] instruction;
  logic        stall;
  logic [3:0]  flags;
  logic [3:0]  ID_opcode, EX_opcode;
  logic [1:0]  ID_AM, EX_AM;
  logic        ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable;
  logic        ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr;
  logic        EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable;
  logic        EX_RW_enable, EX_Enable_signal, EX_BL_instr;
  logic [47:0] keyword;
  logic        Branch, BranchL;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] ex_q_sb[$];

  always #5 clk = ~clk;

  decode_ctrl_stage #(.KW_W(48)) dut (
    .clk(clk), .R(R), .instruction(instruction),
    .stall(stall), .flags(flags),
    .ID_opcode(ID_opcode), .ID_AM(ID_AM),
    .ID_S_enable(ID_S_enable), .ID_load_instr(ID_load_instr),
    .ID_RF_enable(ID_RF_enable), .ID_Size_enable(ID_Size_enable),
    .ID_RW_enable(ID_RW_enable), .ID_Enable_signal(ID_Enable_signal),
    .ID_BL_instr(ID_BL_instr), .ID_B_instr(ID_B_instr),
    .keyword(keyword), .Branch(Branch), .BranchL(BranchL),
    .EX_opcode(EX_opcode), .EX_AM(EX_AM),
    .EX_S_enable(EX_S_enable), .EX_load_instr(EX_load_instr),
    .EX_RF_enable(EX_RF_enable), .EX_Size_enable(EX_Size_enable),
    .EX_RW_enable(EX_RW_enable), .EX_Enable_signal(EX_Enable_signal),
    .EX_BL_instr(EX_BL_instr)
  );

  wire [13:0] id_vec = {ID_opcode, ID_AM, ID_S_enable, ID_load_instr,
                        ID_RF_enable, ID_Size_enable, ID_RW_enable,
                        ID_Enable_signal, ID_BL_instr, ID_B_instr};
  wire [12:0] ex_vec = {EX_opcode, EX_AM, EX_S_enable, EX_load_instr,
                        EX_RF_enable, EX_Size_enable, EX_RW_enable,
                        EX_Enable_signal, EX_BL_instr};

  // {op[13:10], am[9:8], s, ld, rf, sz, rw, en, bl, b}
  function automatic logic [13:0] exp_id(input logic [31:0] i,
                                         input logic st);
    logic [3:0] op;
    logic [1:0] am;
    logic s, ld, rf, sz, rw, en, bl, b;
    {op, am, s, ld, rf, sz, rw, en, bl, b} = '0;
    if (!st && i != 32'h0) begin
      if (i[27:26] == 2'b00) begin
        op = i[24:21];
        am = i[25] ? 2'b00 : 2'b01;
        s  = i[20];
        rf = !(op >= 4'd8 && op <= 4'd11);
      end else if (i[27:26] == 2'b01) begin
        op = i[23] ? 4'd4 : 4'd2;
        am = i[25] ? 2'b11 : 2'b10;
        en = 1'b1;
        ld = i[20];
        rf = i[20];
        rw = ~i[20];
        sz = ~i[22];
      end else if (i[27:25] == 3'b101) begin
        op = 4'd4;
        b  = ~i[24];
        bl = i[24];
      end
    end
    return {op, am, s, ld, rf, sz, rw, en, bl, b};
  endfunction

  function automatic logic [47:0] pad6(input string s);
    logic [47:0] r;
    r = {6{8'h20}};
    for (int k = 0; k < s.len(); k++) r[47-8*k -: 8] = s[k];
    return r;
  endfunction

  function automatic logic [47:0] exp_kw(input logic [31:0] i);
    string dp[16] = '{"AND", "EOR", "SUB", "RSB", "ADD", "ADC", "SBC",
                      "RSC", "TST", "TEQ", "CMP", "CMN", "ORR", "MOV",
                      "BIC", "MVN"};
    string s;
    s = "NOP";
    if (i != 32'h0) begin
      if (i[27:26] == 2'b00) s = dp[i[24:21]];
      else if (i[27:26] == 2'b01)
        s = {i[20] ? "LDR" : "STR", i[22] ? "B" : ""};
      else if (i[27:25] == 3'b101) s = i[24] ? "BL" : "B";
    end
    return pad6(s);
  endfunction

  // pairs of conditions are complements; 111x is AL / never
  function automatic logic exp_cond(input logic [3:0] c,
                                    input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic drive(input logic [31:0] i, input logic st,
                       input logic [3:0] f);
    @(negedge clk);
    instruction = i;
    stall = st;
    flags = f;
    #1;
  endtask

  task automatic test_reset;
    R = 1'b0;
    drive(32'hE2811001, 1'b0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if (ex_vec !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_ex got=%h exp=%h", ex_vec, 13'h0);
    end
    R = 1'b1;
  endtask

  task automatic test_plan_vectors;
    logic [31:0] v[6] = '{32'hE2811001, 32'hE1510002, 32'hE5912000,
                          32'hE5C12004, 32'h0A000002, 32'hEB000004};
    logic [13:0] e[6] = '{{4'b0100, 2'b00, 8'b00100000},
                          {4'b1010, 2'b01, 8'b10000000},
                          {4'b0100, 2'b10, 8'b01110100},
                          {4'b0100, 2'b10, 8'b00001100},
                          {4'b0100, 2'b00, 8'b00000001},
                          {4'b0100, 2'b00, 8'b00000010}};
    logic [1:0] br[6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11};
    for (int k = 0; k < 6; k++) begin
      drive(v[k], 1'b0, 4'b0100);
      n_tests++;
      if (id_vec !== e[k] || {Branch, BranchL} !== br[k]) begin
        n_fail++;
        $display("FAIL plan_%0d got=%h/%b exp=%h/%b", k, id_vec,
                 {Branch, BranchL}, e[k], br[k]);
      end
      ex_q_sb.push_back(e[k][13:1]);
      @(posedge clk); #1;
      n_tests++;
      if (ex_q_sb.size() == 0) begin
        n_fail++;
        $display("FAIL plan_ex_%0d got=empty exp=entry", k);
      end else if (ex_vec !== ex_q_sb[0]) begin
        n_fail++;
        $display("FAIL plan_ex_%0d got=%h exp=%h", k, ex_vec, ex_q_sb[0]);
        void'(ex_q_sb.pop_front());
      end else void'(ex_q_sb.pop_front());
    end
    drive(32'hE2811001, 1'b0, 4'h0);
    n_tests++;
    if (keyword !== pad6("ADD")) begin
      n_fail++;
      $display("FAIL kw_add got=%s exp=ADD", keyword);
    end
    drive(32'hE5C12004, 1'b0, 4'h0);
    n_tests++;
    if (keyword !== pad6("STRB")) begin
      n_fail++;
      $display("FAIL kw_strb got=%s exp=STRB", keyword);
    end
    drive(32'h0A000002, 1'b0, 4'b0000);
    n_tests++;
    if (Branch !== 1'b0 || BranchL !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_z0 got=%b%b exp=00", Branch, BranchL);
    end
    drive(32'h00000000, 1'b0, 4'hF);
    n_tests++;
    if (id_vec !== 14'h0 || keyword !== pad6("NOP")) begin
      n_fail++;
      $display("FAIL zero_word got=%h/%s exp=0/NOP", id_vec, keyword);
    end
  endtask

  task automatic test_dp_opcodes;
    logic [31:0] i;
    for (int op = 0; op < 16; op++) begin
      for (int imm = 0; imm < 2; imm++) begin
        i = {4'hE, 2'b00, imm[0], op[3:0], imm[0] ^ op[0], 20'h12345};
        drive(i, 1'b0, 4'h0);
        n_tests++;
        if (id_vec !== exp_id(i, 1'b0) || keyword !== exp_kw(i)) begin
          n_fail++;
          $display("FAIL dp_%0d_%0d got=%h/%s exp=%h/%s", op, imm,
                   id_vec, keyword, exp_id(i, 1'b0), exp_kw(i));
        end
      end
    end
  endtask

  task automatic test_cond;
    logic [31:0] i;
    logic        eb;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        i = {c[3:0], 3'b101, f[0], 24'h000010};
        drive(i, 1'b0, f[3:0]);
        eb = exp_cond(c[3:0], f[3:0]);
        n_tests++;
        if (Branch !== eb || BranchL !== (eb & f[0])) begin
          n_fail++;
          $display("FAIL cond_%h_%h got=%b%b exp=%b%b", c[3:0], f[3:0],
                   Branch, BranchL, eb, eb & f[0]);
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] v[4] = '{32'hEB000004, 32'hE5912000, 32'hE2811001,
                          32'hEA000001};
    for (int k = 0; k < 4; k++) begin
      drive(v[k], 1'b1, 4'hF);
      n_tests++;
      if (id_vec !== 14'h0 || Branch !== 1'b0 || BranchL !== 1'b0 ||
          keyword !== exp_kw(v[k])) begin
        n_fail++;
        $display("FAIL stall_%0d got=%h/%b/%s exp=0/0/%s", k, id_vec,
                 Branch, keyword, exp_kw(v[k]));
      end
      @(posedge clk); #1;
      n_tests++;
      if (ex_vec !== 13'h0) begin
        n_fail++;
        $display("FAIL stall_ex_%0d got=%h exp=0", k, ex_vec);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] i;
    logic        st;
    logic [13:0] e;
    for (int k = 0; k < 200; k++) begin
      i  = $urandom;
      st = ($urandom_range(0, 5) == 0);
      drive(i, st, 4'($urandom));
      e = exp_id(i, st);
      n_tests++;
      if (id_vec !== e || keyword !== exp_kw(i)) begin
        n_fail++;
        $display("FAIL b2b_id_%0d got=%h/%s exp=%h/%s i=%h", k, id_vec,
                 keyword, e, exp_kw(i), i);
      end
      ex_q_sb.push_back(e[13:1]);
      @(posedge clk); #1;
      n_tests++;
      if (ex_q_sb.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_ex_%0d got=empty exp=entry", k);
      end else if (ex_vec !== ex_q_sb[0]) begin
        n_fail++;
        $display("FAIL b2b_ex_%0d got=%h exp=%h", k, ex_vec, ex_q_sb[0]);
        void'(ex_q_sb.pop_front());
      end else void'(ex_q_sb.pop_front());
    end
  endtask

  task automatic test_reset_mid;
    drive(32'hE5912000, 1'b0, 4'h0);
    @(posedge clk); #1;
    n_tests++;
    if (ex_vec !== exp_id(32'hE5912000, 1'b0) >> 1) begin
      n_fail++;
      $display("FAIL pre_rst_ex got=%h exp=%h", ex_vec,
               exp_id(32'hE5912000, 1'b0) >> 1);
    end
    drive(32'hE2811001, 1'b0, 4'h0);
    R = 1'b0;
    #1;
    n_tests++;
    if (ID_opcode !== 4'b0100 || ID_RF_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL id_in_rst got=%h exp=4/1", ID_opcode);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ex_vec !== 13'h0 || EX_opcode !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_rst_ex got=%h exp=0", ex_vec);
    end
    R = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (EX_opcode !== 4'b0100 || EX_RF_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_ex got=%h exp=%h", ex_vec,
               exp_id(32'hE2811001, 1'b0) >> 1);
    end
  endtask

  initial begin
    R = 1'b0;
    instruction = '0;
    stall = 1'b0;
    flags = '0;
    test_reset;
    test_plan_vectors;
    test_dp_opcodes;
    test_cond;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
